// File: rtl/queue_bank_fifo_pkg.sv
// Shared sizing defaults and helpers for the queue bank and the arbiter that drains it.
package queue_bank_fifo_pkg;

    localparam int unsigned QUEUE_QUANTITY_DEF = 4;
    localparam int unsigned DATA_BITS_DEF      = 8;
    localparam int unsigned BUF_WIDTH_DEF      = 3;

    // Selector width; a single-queue bank still needs a 1-bit selector port.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/queue_bank_fifo_fifo_queue.sv
// One FIFO queue: storage, pointers, occupancy count and a sticky overflow flag.
module fifo_queue
    import queue_bank_fifo_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF,
    parameter int unsigned BUF_WIDTH = BUF_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enb,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 pop_ok,
    output logic [BUF_WIDTH-1:0] count,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow_err
);

    localparam int unsigned          DEPTH   = 2 ** BUF_WIDTH;
    localparam logic [BUF_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [BUF_WIDTH-1:0] wr_ptr;
    logic [BUF_WIDTH-1:0] rd_ptr;
    logic                 push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    // Pop only from a non-empty queue; a simultaneous pop frees the slot a push into a full queue needs.
    assign pop_ok  = enb && pop && !empty;
    assign push_ok = enb && push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            if (enb && push && !push_ok) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/queue_bank_fifo.sv
// Bank of independent FIFO queues feeding a single registered output bus under arbiter control.
module queue_bank_fifo
    import queue_bank_fifo_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = QUEUE_QUANTITY_DEF,
    parameter int unsigned DATA_BITS      = DATA_BITS_DEF,
    parameter int unsigned BUF_WIDTH      = BUF_WIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enb,
    input  logic [QUEUE_QUANTITY-1:0]           push,
    input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_in,
    input  logic [sel_width(QUEUE_QUANTITY)-1:0] selector,
    input  logic                                selector_enb,
    output logic [DATA_BITS-1:0]                data_out,
    output logic                                data_out_valid,
    output logic [QUEUE_QUANTITY-1:0]           buf_empty,
    output logic [QUEUE_QUANTITY-1:0]           buf_full,
    output logic [QUEUE_QUANTITY*BUF_WIDTH-1:0] fifo_counter,
    output logic [QUEUE_QUANTITY-1:0]           overflow_err,
    output logic                                underflow_err
);

    localparam int unsigned SEL_W = sel_width(QUEUE_QUANTITY);

    logic [QUEUE_QUANTITY-1:0] pop_req;
    logic [QUEUE_QUANTITY-1:0] pop_ok;
    logic [DATA_BITS-1:0]      rd_data [QUEUE_QUANTITY];
    logic [DATA_BITS-1:0]      pop_data;
    logic                      any_pop;
    logic                      underflow_hit;

    // Selector values beyond the last queue decode to no strobe and are silently ignored.
    for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_queue
        assign pop_req[i] = selector_enb && (selector == SEL_W'(i));

        fifo_queue #(
            .DATA_BITS (DATA_BITS),
            .BUF_WIDTH (BUF_WIDTH)
        ) u_queue (
            .clk          (clk),
            .rst          (rst),
            .enb          (enb),
            .push         (push[i]),
            .data_in      (data_in[i*DATA_BITS +: DATA_BITS]),
            .pop          (pop_req[i]),
            .rd_data      (rd_data[i]),
            .pop_ok       (pop_ok[i]),
            .count        (fifo_counter[i*BUF_WIDTH +: BUF_WIDTH]),
            .empty        (buf_empty[i]),
            .full         (buf_full[i]),
            .overflow_err (overflow_err[i])
        );
    end

    // At most one queue pops per cycle, so a priority scan acts as a plain mux.
    always_comb begin
        pop_data = '0;
        any_pop  = 1'b0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (pop_ok[i]) begin
                pop_data = rd_data[i];
                any_pop  = 1'b1;
            end
        end
    end

    assign underflow_hit = enb && |(pop_req & buf_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            underflow_err  <= 1'b0;
        end else begin
            data_out_valid <= any_pop;
            if (any_pop) begin
                data_out <= pop_data;
            end
            if (underflow_hit) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_queue_bank_fifo.sv
// Directed bench for queue_bank_fifo with a per-queue reference model and an output scoreboard.
module tb_queue_bank_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic [3:0]  push;
    logic [31:0] data_in;
    logic [1:0]  selector;
    logic        selector_enb;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic [3:0]  buf_empty;
    logic [3:0]  buf_full;
    logic [11:0] fifo_counter;
    logic [3:0]  overflow_err;
    logic        underflow_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq [4][$];
    logic [7:0] exp_q [$];
    logic [7:0] m_dout;
    logic       m_valid;
    logic [3:0] m_ovf;
    logic       m_unf;

    always #5 clk = ~clk;

    queue_bank_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .enb            (enb),
        .push           (push),
        .data_in        (data_in),
        .selector       (selector),
        .selector_enb   (selector_enb),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .buf_empty      (buf_empty),
        .buf_full       (buf_full),
        .fifo_counter   (fifo_counter),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [11:0] e_cnt;
        logic [3:0]  e_empty;
        logic [3:0]  e_full;
        chk("valid", 32'(data_out_valid), 32'(m_valid));
        if (data_out_valid === 1'b1) begin
            m_dout = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        end
        chk("data_out", 32'(data_out), 32'(m_dout));
        for (int i = 0; i < 4; i++) begin
            e_cnt[3*i +: 3] = 3'(mq[i].size());
            e_empty[i]      = (mq[i].size() == 0);
            e_full[i]       = (mq[i].size() == 7);
        end
        chk("fifo_counter", 32'(fifo_counter), 32'(e_cnt));
        chk("buf_empty", 32'(buf_empty), 32'(e_empty));
        chk("buf_full", 32'(buf_full), 32'(e_full));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
        chk("underflow_err", 32'(underflow_err), 32'(m_unf));
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge.
    task automatic cycle(input logic [3:0] p, input logic [31:0] d, input logic se, input logic [1:0] s);
        int         sz [4];
        logic [3:0] pop_hit;
        push         = p;
        data_in      = d;
        selector_enb = se;
        selector     = s;
        for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
        pop_hit = '0;
        m_valid = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            exp_q.delete();
            m_ovf  = '0;
            m_unf  = 1'b0;
            m_dout = '0;
        end else if (enb) begin
            if (se) begin
                if (sz[s] > 0) begin
                    pop_hit[s] = 1'b1;
                    exp_q.push_back(mq[s].pop_front());
                    m_valid = 1'b1;
                end else begin
                    m_unf = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (p[i]) begin
                    if (sz[i] < 7 || pop_hit[i]) mq[i].push_back(d[8*i +: 8]);
                    else m_ovf[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1;
        enb = 1'b1;
        m_dout = '0;
        m_ovf = '0;
        m_unf = 1'b0;
        cycle(4'b0000, 32'h0, 1'b0, 2'd0);
        rst = 1'b0;
        repeat (3) cycle(4'b0000, 32'h0, 1'b0, 2'd0);

        // Queue 2: three words in, three back-to-back pops.
        cycle(4'b0100, 32'h0011_0000, 1'b0, 2'd0);
        cycle(4'b0100, 32'h0022_0000, 1'b0, 2'd0);
        cycle(4'b0100, 32'h0033_0000, 1'b0, 2'd0);
        repeat (3) cycle(4'b0000, 32'h0, 1'b1, 2'd2);
        cycle(4'b0000, 32'h0, 1'b0, 2'd0);

        // Queue 0: fill, overflow with 0xFF, drain.
        for (int k = 0; k < 7; k++) cycle(4'b0001, 32'(k + 1), 1'b0, 2'd0);
        cycle(4'b0001, 32'h0000_00FF, 1'b0, 2'd0);
        repeat (7) cycle(4'b0000, 32'h0, 1'b1, 2'd0);
        cycle(4'b0000, 32'h0, 1'b0, 2'd0);

        // Queue 1: fill, then push+pop while full across the pointer wrap.
        for (int k = 0; k < 7; k++) cycle(4'b0010, 32'(8'h40 + k) << 8, 1'b0, 2'd0);
        for (int k = 0; k < 13; k++) cycle(4'b0010, 32'(8'h60 + k) << 8, 1'b1, 2'd1);
        repeat (7) cycle(4'b0000, 32'h0, 1'b1, 2'd1);
        cycle(4'b0000, 32'h0, 1'b0, 2'd0);

        // Queue 3: push+pop while empty gives no bypass, then the word pops normally.
        cycle(4'b1000, 32'hA500_0000, 1'b1, 2'd3);
        cycle(4'b0000, 32'h0, 1'b1, 2'd3);
        cycle(4'b0000, 32'h0, 1'b0, 2'd0);

        // Queues 0 and 1 loaded together, pops in flight, then reset.
        for (int k = 0; k < 3; k++) cycle(4'b0011, 32'h2010 + 32'(k) * 32'h0101, 1'b0, 2'd0);
        cycle(4'b0000, 32'h0, 1'b1, 2'd0);
        cycle(4'b0000, 32'h0, 1'b1, 2'd1);
        rst = 1'b1;
        cycle(4'b0011, 32'h5555, 1'b1, 2'd1);
        rst = 1'b0;

        // enb low freezes everything, including error flags.
        enb = 1'b0;
        cycle(4'b0001, 32'h0000_0066, 1'b1, 2'd0);
        enb = 1'b1;
        cycle(4'b0001, 32'h0000_0077, 1'b0, 2'd0);
        enb = 1'b0;
        cycle(4'b0001, 32'h0000_0088, 1'b1, 2'd0);
        enb = 1'b1;
        cycle(4'b0000, 32'h0, 1'b1, 2'd0);
        cycle(4'b0000, 32'h0, 1'b0, 2'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
